// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer feeding a debounce FSM with registered
// level, press/release pulses and an 8-bit press counter. Define LONG_PRESS_EN to build
// the long-press detector; otherwise long_press is tied low.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

    state_t      state;
    logic        s1, s2;
    logic [31:0] dcnt;
    logic        pressed;
    logic        dcnt_done;
    logic        accept_press;

    // Polarity is normalised before the synchronizer so everything downstream is 1 = pressed.
    assign pressed      = ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign dcnt_done    = (dcnt == DEBOUNCE_CYCLES - 1);
    assign accept_press = (state == PRESS_DB) && s2 && dcnt_done;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s1            <= 1'b0;
            s2            <= 1'b0;
            dcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            s1            <= pressed;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_DB;
                        dcnt  <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!s2) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt_done) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        dcnt <= dcnt + 32'd1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= REL_DB;
                        dcnt  <= '0;
                    end
                end
                REL_DB: begin
                    // A bounce back to pressed resumes the press without any pulse.
                    if (s2) begin
                        state <= PRESSED;
                    end else if (dcnt_done) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    logic [31:0] hcnt;
    logic        lp_done;

    // Hold time keeps accumulating while a release is still being debounced.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt       <= '0;
            lp_done    <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (accept_press) begin
                hcnt    <= '0;
                lp_done <= 1'b0;
            end else if ((state == PRESSED || state == REL_DB) && !lp_done) begin
                if (hcnt == LONG_PRESS_CYCLES - 1) begin
                    long_press <= 1'b1;
                    lp_done    <= 1'b1;
                end else begin
                    hcnt <= hcnt + 32'd1;
                end
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept_press;
    assign long_press    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1).
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_count = 8'd0;

    int press_seen   = 0;
    int long_seen    = 0;
    int overlap_seen = 0;
    int wide_seen    = 0;
    logic prev_press = 1'b0;
    logic prev_rel   = 1'b0;

    button_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle, compared later by the scenario tasks.
    always @(negedge clk) begin
        if (press_pulse === 1'b1) press_seen++;
        if (long_press === 1'b1) long_seen++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap_seen++;
        if ((press_pulse === 1'b1 && prev_press) || (release_pulse === 1'b1 && prev_rel)) wide_seen++;
        prev_press = (press_pulse === 1'b1);
        prev_rel   = (release_pulse === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_press();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (press_pulse === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_press: press_pulse never seen, required within 20 cycles");
        end
    endtask

    task automatic wait_release();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (release_pulse === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_release: release_pulse never seen, required within 20 cycles");
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 1'b1;
        step();
        step();
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_press} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000",
                     {btn_level, press_pulse, release_pulse, long_press});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", press_count);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL idle_level: got %b required 0", btn_level);
        end
    endtask

    // Press accepted exactly at edge 7 after the pin changes.
    task automatic test_press();
        btn_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (btn_level !== 1'b0 || press_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL press_edge6: level=%b pulse=%b required 0 0", btn_level, press_pulse);
                end
            end else if (k == 7) begin
                exp_count = exp_count + 8'd1;
                checks++;
                if (btn_level !== 1'b1 || press_pulse !== 1'b1 || press_count !== exp_count) begin
                    errors++;
                    $display("FAIL press_edge7: level=%b pulse=%b count=%0d required 1 1 %0d",
                             btn_level, press_pulse, press_count, exp_count);
                end
            end else if (k == 8) begin
                checks++;
                if (btn_level !== 1'b1 || press_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL press_edge8: level=%b pulse=%b required 1 0", btn_level, press_pulse);
                end
            end
        end
    endtask

    task automatic test_release();
        btn_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (btn_level !== 1'b1 || release_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL release_edge6: level=%b pulse=%b required 1 0", btn_level, release_pulse);
                end
            end else if (k == 7) begin
                checks++;
                if (btn_level !== 1'b0 || release_pulse !== 1'b1 || press_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL release_edge7: level=%b rel=%b press=%b required 0 1 0",
                             btn_level, release_pulse, press_pulse);
                end
            end else if (k == 8) begin
                checks++;
                if (release_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL release_edge8: pulse=%b required 0", release_pulse);
                end
            end
        end
    endtask

    task automatic test_bounce();
        bit disturbed = 0;
        btn_raw = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (btn_level !== 1'b0 || press_pulse !== 1'b0) disturbed = 1;
        end
        btn_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (btn_level !== 1'b0 || press_pulse !== 1'b0) disturbed = 1;
        end
        checks++;
        if (disturbed || press_count !== exp_count) begin
            errors++;
            $display("FAIL bounce: disturbed=%b count=%0d required 0 %0d", disturbed, press_count, exp_count);
        end
    endtask

    task automatic test_long_press();
        int base = long_seen;
        btn_raw = 1'b0;
        wait_press();
        exp_count = exp_count + 8'd1;
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k >= 8 && k <= 11) begin
                logic exp_lp;
`ifdef LONG_PRESS_EN
                exp_lp = (k == 10);
`else
                exp_lp = 1'b0;
`endif
                checks++;
                if (long_press !== exp_lp) begin
                    errors++;
                    $display("FAIL long_press_k%0d: got %b required %b", k, long_press, exp_lp);
                end
            end
        end
        btn_raw = 1'b1;
        wait_release();
        checks++;
`ifdef LONG_PRESS_EN
        if (long_seen - base !== 1) begin
            errors++;
            $display("FAIL long_press_once: got %0d pulses required 1", long_seen - base);
        end
`else
        if (long_seen - base !== 0) begin
            errors++;
            $display("FAIL long_press_off: got %0d pulses required 0", long_seen - base);
        end
`endif
    endtask

    task automatic test_reset_mid_debounce();
        int base;
        step();
        step();
        btn_raw = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        base  = press_seen;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_count = 8'd0;
        checks++;
        if (btn_level !== 1'b0 || press_pulse !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_db_reset: level=%b pulse=%b count=%0d required 0 0 0",
                     btn_level, press_pulse, press_count);
        end
        // Button still held: a full debounce is needed before the fresh press.
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (btn_level !== 1'b0 || press_seen !== base) begin
                    errors++;
                    $display("FAIL mid_db_hold6: level=%b presses=%0d required 0 %0d",
                             btn_level, press_seen, base);
                end
            end
        end
        exp_count = exp_count + 8'd1;
        checks++;
        if (btn_level !== 1'b1 || press_pulse !== 1'b1 || press_count !== exp_count) begin
            errors++;
            $display("FAIL mid_db_fresh: level=%b pulse=%b count=%0d required 1 1 %0d",
                     btn_level, press_pulse, press_count, exp_count);
        end
        btn_raw = 1'b1;
        wait_release();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_count = 8'd0;
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b0;
            wait_press();
            exp_count = exp_count + 8'd1;
            btn_raw = 1'b1;
            wait_release();
            if (i == 254) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: got %0d required 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== exp_count || press_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap: got %0d required 0", press_count);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (overlap_seen !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles required 0", overlap_seen);
        end
        checks++;
        if (wide_seen !== 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d wide pulses required 0", wide_seen);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_long_press();
        test_reset_mid_debounce();
        test_wrap();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
